sipo_collector: RTL and testbench

Serial-in, parallel-out collector: the receiving end of the team's right-shifting parallel-to-serial register. It accepts a stream of `WIDTH` bits, least-significant bit first, under a per-bit valid strobe, and assembles them into a parallel word. The completed word is presented on a valid/ready handshake. It sits at the serial product output of the signed 8x8 serial-parallel multiplier datapath, rebuilding the 16-bit product for downstream logic.

---
 rtl/sipo_pkg.sv | 12 +
 rtl/sipo_collector_if.sv | 25 ++
 rtl/sipo_bit_counter.sv | 27 ++
 rtl/sipo_collector.sv | 93 +++++++++
 tb/tb_sipo_collector.sv | 175 +++++++++++++++++
 5 files changed

// File: rtl/sipo_pkg.sv
// Shared types and constants for the serial-in, parallel-out collector.
package sipo_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    HOLD    = 2'd2
  } sipo_state_t;

  localparam int SIPO_DEFAULT_WIDTH = 16;

endpackage

// File: rtl/sipo_collector_if.sv
// Serial input strobe plus valid/ready word output of the SIPO collector.
interface sipo_collector_if
  import sipo_pkg::*;
#(
  parameter int WIDTH = SIPO_DEFAULT_WIDTH
);
  logic             start;
  logic             bit_valid;
  logic             bit_in;
  logic [WIDTH-1:0] word;
  logic             word_valid;
  logic             word_ready;
  logic             busy;
  logic             overrun;

  modport master (
    output start, bit_valid, bit_in, word_ready,
    input  word, word_valid, busy, overrun
  );

  modport slave (
    input  start, bit_valid, bit_in, word_ready,
    output word, word_valid, busy, overrun
  );
endinterface

// File: rtl/sipo_bit_counter.sv
// Modulo-WIDTH bit counter; last flags the final bit position of a word.
module sipo_bit_counter
  import sipo_pkg::*;
#(
  parameter int WIDTH = SIPO_DEFAULT_WIDTH
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic inc,
  output logic last
);
  localparam int CW = $clog2(WIDTH);

  logic [CW-1:0] cnt;

  assign last = (cnt == CW'(WIDTH - 1));

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt <= '0;
    end else if (inc) begin
      cnt <= last ? '0 : cnt + CW'(1);
    end
  end
endmodule

// File: rtl/sipo_collector.sv
// Serial-in, parallel-out collector: LSB-first bits shifted into a word, presented on valid/ready.
// Optional sticky overrun flag for bits arriving in HOLD is enabled by defining SIPO_OVERRUN_EN.
module sipo_collector
  import sipo_pkg::*;
#(
  parameter int WIDTH = SIPO_DEFAULT_WIDTH
) (
  input logic               clk,
  input logic               rst,
  sipo_collector_if.slave   bus
);
  sipo_state_t      state_q, state_d;
  logic [WIDTH-1:0] word_q, word_d;
  logic             cnt_clr, cnt_inc, cnt_last;

  sipo_bit_counter #(.WIDTH(WIDTH)) u_cnt (
    .clk  (clk),
    .rst  (rst),
    .clr  (cnt_clr),
    .inc  (cnt_inc),
    .last (cnt_last)
  );

`ifdef SIPO_OVERRUN_EN
  logic overrun_q, overrun_d;
`endif

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    word_d  = word_q;
    cnt_clr = 1'b0;
    cnt_inc = 1'b0;
`ifdef SIPO_OVERRUN_EN
    overrun_d = overrun_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          state_d = COLLECT;
          word_d  = '0;
          cnt_clr = 1'b1;
`ifdef SIPO_OVERRUN_EN
          overrun_d = 1'b0;
`endif
        end
      end
      COLLECT: begin
        // A restart wins over a coincident bit, which is dropped.
        if (bus.start) begin
          word_d  = '0;
          cnt_clr = 1'b1;
        end else if (bus.bit_valid) begin
          word_d  = {bus.bit_in, word_q[WIDTH-1:1]};
          cnt_inc = 1'b1;
          if (cnt_last) state_d = HOLD;
        end
      end
      HOLD: begin
        if (bus.word_ready) state_d = IDLE;
`ifdef SIPO_OVERRUN_EN
        if (bus.bit_valid) overrun_d = 1'b1;
`endif
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      word_q  <= '0;
    end else begin
      state_q <= state_d;
      word_q  <= word_d;
    end
  end

`ifdef SIPO_OVERRUN_EN
  always_ff @(posedge clk) begin
    if (rst) overrun_q <= 1'b0;
    else     overrun_q <= overrun_d;
  end
  assign bus.overrun = overrun_q;
`else
  assign bus.overrun = 1'b0;
`endif

  // Status outputs decode straight from registers; no input reaches them combinationally.
  assign bus.word       = word_q;
  assign bus.word_valid = (state_q == HOLD);
  assign bus.busy       = (state_q == COLLECT);
endmodule

// File: tb/tb_sipo_collector.sv
// Directed bench for sipo_collector: expected words queued on stimulus, popped on word_valid.
module tb_sipo_collector;
  localparam int W = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   failures = 0;
  logic [W-1:0] sb_q[$];
  logic [W-1:0] held;

  sipo_collector_if #(.WIDTH(W)) bus ();

  sipo_collector #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

`ifdef SIPO_OVERRUN_EN
  localparam logic OVR_EXP = 1'b1;
`else
  localparam logic OVR_EXP = 1'b0;
`endif

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Start a collection and shift in data LSB first; gap cycles follow bits 4 and 11.
  task automatic collect_word(input logic [W-1:0] data, input int gap);
    sb_q.push_back(data);
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    check("busy_after_start", bus.busy, 1);
    for (int i = 0; i < W; i++) begin
      bus.bit_valid = 1'b1;
      bus.bit_in    = data[i];
      step();
      bus.bit_valid = 1'b0;
      if (i < W - 1 && bus.word_valid !== 1'b0)
        check("early_word_valid", bus.word_valid, 0);
      if (i == 3 || i == 10) begin
        for (int g = 0; g < gap; g++) begin
          step();
          check("gap_word_valid", bus.word_valid, 0);
        end
      end
    end
    check("word_valid_latency", bus.word_valid, 1);
    check("busy_falls", bus.busy, 0);
    if (bus.word_valid === 1'b1) begin
      if (sb_q.size() == 0) check("scoreboard_empty", 1, 0);
      else check("word", bus.word, sb_q.pop_front());
    end
  endtask

  task automatic transfer();
    held = bus.word;
    bus.word_ready = 1'b1;
    step();
    bus.word_ready = 1'b0;
    check("valid_after_xfer", bus.word_valid, 0);
    check("idle_after_xfer", bus.busy, 0);
    check("word_kept", bus.word, held);
  endtask

  initial begin
    bus.start = 1'b0; bus.bit_valid = 1'b0; bus.bit_in = 1'b0; bus.word_ready = 1'b0;
    step(); step();
    rst = 1'b0;
    check("rst_word", bus.word, 0);
    check("rst_valid", bus.word_valid, 0);
    check("rst_busy", bus.busy, 0);
    check("rst_overrun", bus.overrun, 0);

    // Back-to-back bits, then immediate hand-off.
    collect_word(16'hA5C3, 0);
    transfer();

    // Gapped bits; consumer stalls 5 cycles; start in HOLD ignored.
    collect_word(16'hA5C3, 3);
    held = bus.word;
    for (int i = 0; i < 5; i++) begin
      bus.start = (i == 2);
      step();
      check("stall_valid", bus.word_valid, 1);
      check("stall_word", bus.word, held);
      check("stall_busy", bus.busy, 0);
    end
    bus.start = 1'b0;
    // start coinciding with the transfer is also ignored.
    bus.start = 1'b1;
    transfer();
    bus.start = 1'b0;

    // Restart after 7 bits of ones, then 16'h8001.
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    for (int i = 0; i < 7; i++) begin
      bus.bit_valid = 1'b1; bus.bit_in = 1'b1;
      step();
    end
    bus.bit_valid = 1'b0;
    check("partial_busy", bus.busy, 1);
    collect_word(16'h8001, 0);

    // Bits arriving in HOLD.
    held = bus.word;
    bus.bit_valid = 1'b1; bus.bit_in = 1'b0;
    step(); step();
    bus.bit_valid = 1'b0;
    check("hold_word_frozen", bus.word, held);
    check("overrun_set", bus.overrun, OVR_EXP);
    transfer();
    check("overrun_sticky", bus.overrun, OVR_EXP);
    // start with a coincident bit in IDLE: bit dropped, overrun cleared.
    sb_q.push_back(16'h1234);
    bus.start = 1'b1; bus.bit_valid = 1'b1; bus.bit_in = 1'b1;
    step();
    bus.start = 1'b0; bus.bit_valid = 1'b0;
    check("overrun_cleared", bus.overrun, 0);
    for (int i = 0; i < W; i++) begin
      bus.bit_valid = 1'b1; bus.bit_in = held[i] ^ 1'b1;
      bus.bit_in = logic'((16'h1234 >> i) & 1);
      step();
    end
    bus.bit_valid = 1'b0;
    check("dropped_bit_valid", bus.word_valid, 1);
    if (sb_q.size() != 0) check("dropped_bit_word", bus.word, sb_q.pop_front());
    transfer();

    // Reset mid-word, then a clean word.
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    for (int i = 0; i < 9; i++) begin
      bus.bit_valid = 1'b1; bus.bit_in = 1'b1;
      step();
    end
    bus.bit_valid = 1'b0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("midrst_word", bus.word, 0);
    check("midrst_valid", bus.word_valid, 0);
    check("midrst_busy", bus.busy, 0);
    check("midrst_overrun", bus.overrun, 0);
    collect_word(16'h1234, 0);
    transfer();

    check("scoreboard_drained", sb_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule
